// File: rtl/stokes_gain_pkg.sv
// rtl/stokes_gain_pkg.sv - shared widths, constants and peak FSM state for stokes_gain_array
//
// Contents: datapath widths (IN_W, OUT_W, COEFF_W, SHIFT_W, MID_W, COEFF_FRAC),
// unity gain value for shadow reset, saturation counter width, peak FSM enum.

package stokes_gain_pkg;

    localparam int IN_W       = 48;
    localparam int OUT_W      = 16;
    localparam int COEFF_W    = 16;
    localparam int SHIFT_W    = 6;
    localparam int MID_W      = 24;
    localparam int COEFF_FRAC = 8;
    localparam int SAT_CNT_W  = 16;

    // Q8.8 value 1.0
    localparam logic [COEFF_W-1:0] COEFF_UNITY = 16'h0100;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } peak_state_e;

endpackage

// File: rtl/gain_lane.sv
// rtl/gain_lane.sv - one channel of the gain stage: shift, clip, Q8.8 multiply, saturate, |x|
//
// Parameter: SIGNED - 1: channel is two's complement, 0: unsigned
// Ports:
//   x_i      in   IN_W     integrated sample
//   shift_i  in   SHIFT_W  right shift amount (values above IN_W-1 act as IN_W-1)
//   coeff_i  in   COEFF_W  unsigned Q8.8 gain
//   y_o      out  OUT_W    gained and saturated result (combinational)
//   sat_o    out  1        clip occurred in the 24-bit or 16-bit saturation step
//   mag_o    out  IN_W     |x_i| (for signed -2^47 this is 2^47 as an unsigned value)

module gain_lane
    import stokes_gain_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic [IN_W-1:0]    x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [COEFF_W-1:0] coeff_i,
    output logic [OUT_W-1:0]   y_o,
    output logic               sat_o,
    output logic [IN_W-1:0]    mag_o
);

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(IN_W - 1);
    localparam int PROD_W = MID_W + COEFF_W;
    localparam int SCL_W  = PROD_W - COEFF_FRAC;

    logic [SHIFT_W-1:0] sh;
    logic               clip_mid;
    logic               clip_out;

    assign sh    = (shift_i > SHIFT_MAX) ? SHIFT_MAX : shift_i;
    // Both clips in one bin are a single event
    assign sat_o = clip_mid | clip_out;

    if (SIGNED) begin : g_signed
        logic signed [IN_W-1:0]   shifted;
        logic signed [MID_W-1:0]  mid;
        logic signed [PROD_W:0]   prod;
        logic signed [SCL_W:0]    scaled;
        logic [COEFF_FRAC-1:0]    unused_frac;

        always_comb begin
            shifted  = $signed(x_i) >>> sh;
            // In range only when the bits above the 24-bit field are pure sign extension
            clip_mid = !((&shifted[IN_W-1:MID_W-1]) || !(|shifted[IN_W-1:MID_W-1]));
            if (clip_mid) begin
                mid = shifted[IN_W-1] ? {1'b1, {(MID_W-1){1'b0}}} : {1'b0, {(MID_W-1){1'b1}}};
            end else begin
                mid = shifted[MID_W-1:0];
            end
            // Coefficient is unsigned, so it enters the signed product with a zero MSB
            prod        = (PROD_W+1)'(mid) * (PROD_W+1)'($signed({1'b0, coeff_i}));
            scaled      = prod[PROD_W:COEFF_FRAC];
            unused_frac = prod[COEFF_FRAC-1:0];
            clip_out    = !((&scaled[SCL_W:OUT_W-1]) || !(|scaled[SCL_W:OUT_W-1]));
            if (clip_out) begin
                y_o = scaled[SCL_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                y_o = scaled[OUT_W-1:0];
            end
            mag_o = x_i[IN_W-1] ? (~x_i + IN_W'(1)) : x_i;
        end
    end else begin : g_unsigned
        logic [IN_W-1:0]       shifted;
        logic [MID_W-1:0]      mid;
        logic [PROD_W-1:0]     prod;
        logic [SCL_W-1:0]      scaled;
        logic [COEFF_FRAC-1:0] unused_frac;

        always_comb begin
            shifted     = x_i >> sh;
            clip_mid    = |shifted[IN_W-1:MID_W];
            mid         = clip_mid ? '1 : shifted[MID_W-1:0];
            prod        = PROD_W'(mid) * PROD_W'(coeff_i);
            scaled      = prod[PROD_W-1:COEFF_FRAC];
            unused_frac = prod[COEFF_FRAC-1:0];
            clip_out    = |scaled[SCL_W-1:OUT_W];
            y_o         = clip_out ? '1 : scaled[OUT_W-1:0];
            mag_o       = x_i;
        end
    end

endmodule

// File: rtl/stokes_gain_array.sv
// rtl/stokes_gain_array.sv - multi-channel Stokes gain stage with frame-start gain shadows and peak tracking
//
// Optional feature macro: GAIN_SAT_CNT_EN (per-channel per-frame saturation counters on sat_cnt;
// when undefined sat_cnt is tied to 0).
// Ports:
//   clk           in   1          rising-edge clock
//   rst           in   1          asynchronous active-low reset
//   en_sync_in    in   1          input bin valid
//   cnt_sync_in   in   CNT_W      bin index
//   para_in       in   NCH*48     channel k at [48k+47:48k]
//   coeff_in      in   NCH*16     Q8.8 gain per channel, captured at bin 0
//   shift_in      in   NCH*6      right shift per channel, captured at bin 0
//   en_sync_out   out  1          en_sync_in delayed 3
//   cnt_sync_out  out  CNT_W      cnt_sync_in delayed 3, held when not valid
//   para_out      out  NCH*16     gained output, held when not valid
//   peak_out      out  NCH*48     max |x| over last complete frame
//   peak_valid    out  1          pulse when peak_out updates
//   frame_err     out  1          pulse on bin 0 arriving mid-frame
//   sat_cnt       out  NCH*16     saturation events in last complete frame

module stokes_gain_array
    import stokes_gain_pkg::*;
#(
    parameter int              NCH         = 4,
    parameter int              CNT_W       = 9,
    parameter int              FFT_POINT   = 512,
    parameter logic [NCH-1:0]  SIGNED_MASK = 4'b1100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_sync_in,
    input  logic [CNT_W-1:0]           cnt_sync_in,
    input  logic [NCH*IN_W-1:0]        para_in,
    input  logic [NCH*COEFF_W-1:0]     coeff_in,
    input  logic [NCH*SHIFT_W-1:0]     shift_in,
    output logic                       en_sync_out,
    output logic [CNT_W-1:0]           cnt_sync_out,
    output logic [NCH*OUT_W-1:0]       para_out,
    output logic [NCH*IN_W-1:0]        peak_out,
    output logic                       peak_valid,
    output logic                       frame_err,
    output logic [NCH*SAT_CNT_W-1:0]   sat_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_POINT - 1);

    logic bin_first;
    logic bin_last;
    logic capture;

    assign bin_first = (cnt_sync_in == '0);
    assign bin_last  = (cnt_sync_in == LAST_BIN);
    assign capture   = en_sync_in && bin_first;

    // Gain shadows; the capturing bin itself already uses the new settings
    logic [NCH*COEFF_W-1:0] coeff_q, coeff_eff;
    logic [NCH*SHIFT_W-1:0] shift_q, shift_eff;

    assign coeff_eff = capture ? coeff_in : coeff_q;
    assign shift_eff = capture ? shift_in : shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coeff_q <= {NCH{COEFF_UNITY}};
            shift_q <= '0;
        end else if (capture) begin
            coeff_q <= coeff_in;
            shift_q <= shift_in;
        end
    end

    logic [NCH*OUT_W-1:0] lane_y;
    logic [NCH-1:0]       lane_sat;
    logic [NCH*IN_W-1:0]  lane_mag;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        gain_lane #(
            .SIGNED (SIGNED_MASK[k])
        ) u_lane (
            .x_i     (para_in[k*IN_W +: IN_W]),
            .shift_i (shift_eff[k*SHIFT_W +: SHIFT_W]),
            .coeff_i (coeff_eff[k*COEFF_W +: COEFF_W]),
            .y_o     (lane_y[k*OUT_W +: OUT_W]),
            .sat_o   (lane_sat[k]),
            .mag_o   (lane_mag[k*IN_W +: IN_W])
        );
    end

    // Three-stage output pipeline; lane math is combinational and the later
    // stages give retiming room through the multiplier
    logic                 v1_q, v2_q;
    logic [NCH*OUT_W-1:0] y1_q, y2_q;
    logic [CNT_W-1:0]     c1_q, c2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            y1_q         <= '0;
            y2_q         <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            en_sync_out  <= 1'b0;
            cnt_sync_out <= '0;
            para_out     <= '0;
        end else begin
            v1_q        <= en_sync_in;
            v2_q        <= v1_q;
            en_sync_out <= v2_q;
            if (en_sync_in) begin
                y1_q <= lane_y;
                c1_q <= cnt_sync_in;
            end
            if (v1_q) begin
                y2_q <= y1_q;
                c2_q <= c1_q;
            end
            if (v2_q) begin
                para_out     <= y2_q;
                cnt_sync_out <= c2_q;
            end
        end
    end

    // Peak tracking runs on the input cycle, independent of the data pipeline.
    // A bin 0 always (re)starts a frame, whether from IDLE or mid-frame.
    peak_state_e         state_q;
    logic                tracking;
    logic [NCH*IN_W-1:0] acc_q, acc_d;

    assign tracking = en_sync_in && ((state_q == TRACK) || bin_first);

    always_comb begin
        acc_d = lane_mag;
        for (int k = 0; k < NCH; k++) begin
            if (!bin_first && (acc_q[k*IN_W +: IN_W] > lane_mag[k*IN_W +: IN_W])) begin
                acc_d[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            peak_out   <= '0;
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (tracking) begin
                acc_q     <= acc_d;
                frame_err <= (state_q == TRACK) && bin_first;
                if (bin_last) begin
                    peak_out   <= acc_d;
                    peak_valid <= 1'b1;
                    state_q    <= IDLE;
                end else begin
                    state_q    <= TRACK;
                end
            end
        end
    end

`ifdef GAIN_SAT_CNT_EN
    logic [NCH*SAT_CNT_W-1:0] sat_acc_q, sat_acc_d;

    always_comb begin
        sat_acc_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bin_first) begin
                sat_acc_d[k*SAT_CNT_W +: SAT_CNT_W] = {{(SAT_CNT_W-1){1'b0}}, lane_sat[k]};
            end else if (lane_sat[k] && !(&sat_acc_q[k*SAT_CNT_W +: SAT_CNT_W])) begin
                sat_acc_d[k*SAT_CNT_W +: SAT_CNT_W] = sat_acc_q[k*SAT_CNT_W +: SAT_CNT_W] + SAT_CNT_W'(1);
            end else begin
                sat_acc_d[k*SAT_CNT_W +: SAT_CNT_W] = sat_acc_q[k*SAT_CNT_W +: SAT_CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_acc_q <= '0;
            sat_cnt   <= '0;
        end else if (tracking) begin
            sat_acc_q <= sat_acc_d;
            if (bin_last) begin
                sat_cnt <= sat_acc_d;
            end
        end
    end
`else
    logic unused_sat;

    assign unused_sat = ^lane_sat;
    assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_stokes_gain_array.sv
// tb/tb_stokes_gain_array.sv - directed self-checking bench for stokes_gain_array

module tb_stokes_gain_array;

    localparam int NCH       = 4;
    localparam int CNT_W     = 9;
    localparam int FFT_POINT = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_sync_in;
    logic [CNT_W-1:0]  cnt_sync_in;
    logic [191:0]      para_in;
    logic [63:0]       coeff_in;
    logic [23:0]       shift_in;
    logic              en_sync_out;
    logic [CNT_W-1:0]  cnt_sync_out;
    logic [63:0]       para_out;
    logic [191:0]      peak_out;
    logic              peak_valid;
    logic              frame_err;
    logic [63:0]       sat_cnt;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;
    logic [63:0] exp_sat_a;

    always #5 clk = ~clk;

    stokes_gain_array #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .FFT_POINT   (FFT_POINT),
        .SIGNED_MASK (4'b1100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_sync_in   (en_sync_in),
        .cnt_sync_in  (cnt_sync_in),
        .para_in      (para_in),
        .coeff_in     (coeff_in),
        .shift_in     (shift_in),
        .en_sync_out  (en_sync_out),
        .cnt_sync_out (cnt_sync_out),
        .para_out     (para_out),
        .peak_out     (peak_out),
        .peak_valid   (peak_valid),
        .frame_err    (frame_err),
        .sat_cnt      (sat_cnt)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (peak_valid === 1'b1) pv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    endtask

    // Per-frame stimulus: {ch3, ch2, ch1, ch0}
    function automatic logic [191:0] bin_data(input int fr, input int c);
        logic [47:0] ch0, ch1, ch2, ch3;
        ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
        case (fr)
            0: begin
                if (c == 0)   begin ch0 = 48'h0000_1234_0000; ch2 = 48'hFFFF_FFFF_FF9C; end
                if (c == 37)  ch1 = 48'h0000_0000_7FFF;
                if (c == 50)  ch2 = 48'hFF00_0000_0000;
                if (c == 60)  ch3 = 48'h8000_0000_0000;
                if (c == 200) ch0 = 48'h0000_0001_0000;
                if (c == 511) ch0 = 48'h0000_0005_0000;
            end
            1: begin
                if (c == 0)  ch0 = 48'h0000_0001_0000;
                if (c == 10) ch1 = 48'h8000_0000_0000;
            end
            2: begin
                if (c == 0) ch0 = 48'h0000_0001_0000;
                if (c == 5) ch1 = 48'h0000_0000_0042;
            end
            3: ch0 = 48'h0000_0001_0000;
            default: begin
                if (c == 5) begin
                    ch0 = 48'h0000_0000_0077;
                    ch1 = 48'h0000_0001_0000;
                    ch2 = 48'hFFFF_FFFF_FF9C;
                end
            end
        endcase
        return {ch3, ch2, ch1, ch0};
    endfunction

    task automatic drive_bin(input int fr, input int c);
        en_sync_in  = 1'b1;
        cnt_sync_in = CNT_W'(c);
        para_in     = bin_data(fr, c);
        step();
    endtask

    initial begin
`ifdef GAIN_SAT_CNT_EN
        exp_sat_a = 64'h0001_0001_0000_0000;
`else
        exp_sat_a = 64'h0;
`endif
        rst         = 1'b0;
        en_sync_in  = 1'b0;
        cnt_sync_in = '0;
        para_in     = '0;
        coeff_in    = {16'h0100, 16'h0080, 16'h0100, 16'h0100};
        shift_in    = {6'd0, 6'd0, 6'd0, 6'd16};
        repeat (3) step();
        chk("rst_para_out", para_out, 64'h0);
        chk("rst_en_out", en_sync_out, 1'b0);
        chk("rst_peak", peak_out, 192'h0);
        chk("rst_flags", {peak_valid, frame_err}, 2'b00);
        rst = 1'b1;
        step();

        // Frame A: full frame, gain change mid-frame must not apply yet
        for (int c = 0; c < FFT_POINT; c++) begin
            if (c == 200) begin
                coeff_in[15:0] = 16'h0200;
                shift_in[11:6] = 6'd63;
            end
            drive_bin(0, c);
            if (c == 2) begin
                chk("a_bin0_data", para_out, 64'h0000_FFCE_0000_1234);
                chk("a_bin0_valid", en_sync_out, 1'b1);
                chk("a_bin0_cnt", cnt_sync_out, 9'd0);
            end
            if (c == 39)  chk("a_bin37_data", para_out, 64'h0000_0000_7FFF_0000);
            if (c == 52)  chk("a_bin50_sat", para_out, 64'h0000_8000_0000_0000);
            if (c == 62)  chk("a_bin60_minval", para_out, 64'h8000_0000_0000_0000);
            if (c == 202) chk("a_bin200_oldgain", para_out, 64'h0000_0000_0000_0001);
            if (c == 510) chk("a_no_early_pv", peak_valid, 1'b0);
            if (c == 511) begin
                chk("a_peak_valid", peak_valid, 1'b1);
                chk("a_peak_out", peak_out,
                    {48'h8000_0000_0000, 48'h0100_0000_0000, 48'h0000_0000_7FFF, 48'h0000_1234_0000});
                chk("a_sat_cnt", sat_cnt, exp_sat_a);
            end
        end

        // Idle cycles with garbage data: outputs hold
        en_sync_in  = 1'b0;
        cnt_sync_in = '0;
        para_in     = '1;
        step();
        chk("a_pv_one_cycle", peak_valid, 1'b0);
        step();
        chk("a_bin511_data", para_out, 64'h5);
        chk("a_bin511_cnt", cnt_sync_out, 9'd511);
        step();
        step();
        chk("idle_hold_data", para_out, 64'h5);
        chk("idle_valid_low", en_sync_out, 1'b0);
        chk("idle_hold_cnt", cnt_sync_out, 9'd511);

        // Frame B: new gain takes effect at bin 0, aborted at bin 300
        for (int c = 0; c < 300; c++) begin
            drive_bin(1, c);
            if (c == 2)  chk("b_newgain", para_out, 64'h0000_0000_0000_0002);
            if (c == 12) chk("b_shift_clamp", para_out, 64'h0000_0000_0001_0000);
        end

        // Frame C: restart -> frame_err, then reports only its own peaks
        for (int c = 0; c < FFT_POINT; c++) begin
            drive_bin(2, c);
            if (c == 0)   chk("c_frame_err", frame_err, 1'b1);
            if (c == 1)   chk("c_frame_err_pulse", frame_err, 1'b0);
            if (c == 510) chk("c_no_pv_aborted", pv_cnt, 1);
            if (c == 511) begin
                chk("c_peak_valid", peak_valid, 1'b1);
                chk("c_peak_out", peak_out,
                    {48'h0, 48'h0, 48'h0000_0000_0042, 48'h0000_0001_0000});
                chk("c_sat_cnt", sat_cnt, 64'h0);
            end
        end
        chk("c_fe_count", fe_cnt, 1);

        // Frame D: reset at bin 100
        for (int c = 0; c <= 100; c++) begin
            drive_bin(3, c);
        end
        chk("d_pre_reset_data", para_out, 64'h2);
        rst = 1'b0;
        #1;
        chk("d_rst_para_out", para_out, 64'h0);
        chk("d_rst_cnt_out", cnt_sync_out, 9'd0);
        chk("d_rst_peak", peak_out, 192'h0);
        chk("d_rst_en_out", en_sync_out, 1'b0);
        step();
        step();
        rst = 1'b1;

        // Frame E: starts at cnt=5, default shadows, never reports
        for (int c = 5; c < FFT_POINT; c++) begin
            drive_bin(4, c);
            if (c == 7) chk("e_default_gain", para_out, 64'h0000_FF9C_FFFF_0077);
        end
        en_sync_in = 1'b0;
        repeat (5) step();
        chk("e_no_peak_valid", pv_cnt, 2);
        chk("e_peak_zero", peak_out, 192'h0);
        chk("e_sat_zero", sat_cnt, 64'h0);
        chk("e_no_frame_err", fe_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
